// File: rtl/priority_encoder_serial_if.sv
// Handshake bundle for priority_encoder_serial: load side, index stream and completion pulses.
interface priority_encoder_serial_if #(
  parameter int N = 4
) ();
  localparam int W = $clog2(N);

  logic [N-1:0] din;
  logic         load;
  logic         busy;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         dout_ready;
  logic         dout_last;
  logic         done;
  logic         zero;

  modport master (
    output din, load, dout_ready,
    input  busy, dout, dout_valid, dout_last, done, zero
  );

  modport slave (
    input  din, load, dout_ready,
    output busy, dout, dout_valid, dout_last, done, zero
  );
endinterface

// File: rtl/priority_encoder_serial.sv
// Serial priority encoder: captures a multi-hot vector and streams one set-bit index per handshake.
// PENC_MSB_FIRST_EN selects highest-index-first order; default is lowest-index-first.
module priority_encoder_serial #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input logic                     clk,
  input logic                     rst_n,
  priority_encoder_serial_if.slave bus
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   pend_q, pend_d;
  logic [W-1:0]   dout_q, dout_d;
  logic           last_q, last_d;
  logic           done_q, done_d;
  logic           zero_q, zero_d;

  logic [N-1:0]   src;
  logic [W-1:0]   hit_idx;
  logic [N-1:0]   pend_clr;

  // One finder serves both the freshly loaded vector and the pending bits.
  assign src = (state_q == SCAN) ? pend_q : bus.din;

  always_comb begin
    hit_idx = '0;
`ifdef PENC_MSB_FIRST_EN
    for (int i = 0; i < N; i++)
      if (src[i]) hit_idx = W'(i);
`else
    for (int i = N - 1; i >= 0; i--)
      if (src[i]) hit_idx = W'(i);
`endif
  end

  assign pend_clr = src & ~(N'(1) << hit_idx);

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    dout_d  = dout_q;
    last_d  = last_q;
    done_d  = 1'b0;
    zero_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.load) begin
          if (|bus.din) begin
            state_d = SCAN;
            dout_d  = hit_idx;
            pend_d  = pend_clr;
            last_d  = ~|pend_clr;
          end else begin
            done_d = 1'b1;
            zero_d = 1'b1;
          end
        end
      end
      SCAN: begin
        if (bus.dout_ready) begin
          if (last_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
            dout_d  = '0;
            last_d  = 1'b0;
            pend_d  = '0;
          end else begin
            dout_d = hit_idx;
            pend_d = pend_clr;
            last_d = ~|pend_clr;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      dout_q  <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      dout_q  <= dout_d;
      last_q  <= last_d;
      done_q  <= done_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.busy       = (state_q == SCAN);
  assign bus.dout_valid = (state_q == SCAN);
  assign bus.dout       = dout_q;
  assign bus.dout_last  = last_q;
  assign bus.done       = done_q;
  assign bus.zero       = zero_q;

endmodule

// File: tb/tb_priority_encoder_serial.sv
// Scoreboard bench for priority_encoder_serial: directed cases plus randomized loads and backpressure.
module tb_priority_encoder_serial;
  localparam int N = 4;
  localparam int W = $clog2(N);
`ifdef PENC_MSB_FIRST_EN
  localparam bit MSB = 1'b1;
`else
  localparam bit MSB = 1'b0;
`endif

  logic clk;
  logic rst_n;

  priority_encoder_serial_if #(.N(N)) bus ();

  priority_encoder_serial #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit is_done;
    bit zero;
    int idx;
    bit last;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  // Reference: the set bits of v in priority order, then a done marker.
  task automatic push_model(input logic [N-1:0] v);
    int   k    = 0;
    int   seen = 0;
    exp_t e;
    for (int i = 0; i < N; i++) if (v[i]) k++;
    for (int p = 0; p < N; p++) begin
      int i;
      i = MSB ? (N - 1 - p) : p;
      if (v[i]) begin
        seen++;
        e.is_done = 1'b0; e.zero = 1'b0; e.idx = i; e.last = (seen == k);
        exp_q.push_back(e);
      end
    end
    e.is_done = 1'b1; e.zero = (k == 0); e.idx = 0; e.last = 1'b0;
    exp_q.push_back(e);
  endtask

  function automatic int first_idx(input logic [N-1:0] v);
    for (int p = 0; p < N; p++) begin
      int i;
      i = MSB ? (N - 1 - p) : p;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // Monitor: pops on every handshake or done pulse, and checks stall stability.
  bit           stall_prev = 1'b0;
  logic [W-1:0] dout_prev;
  logic         last_prev;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", int'(bus.dout_valid), 1);
        chk("stall_dout", int'(bus.dout), int'(dout_prev));
        chk("stall_last", int'(bus.dout_last), int'(last_prev));
      end
      if (bus.done) begin
        chk("done_no_valid", int'(bus.dout_valid), 0);
        if (exp_q.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("done_expected", int'(e.is_done), 1);
          chk("zero_flag", int'(bus.zero), int'(e.zero));
        end
      end else if (bus.zero) begin
        chk("zero_without_done", 1, 0);
      end
      if (bus.dout_valid && bus.dout_ready) begin
        chk("busy_in_scan", int'(bus.busy), 1);
        if (exp_q.size() == 0) chk("index_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("index_not_done", int'(e.is_done), 0);
          chk("dout", int'(bus.dout), e.idx);
          chk("dout_last", int'(bus.dout_last), int'(e.last));
        end
      end
      stall_prev = bus.dout_valid && !bus.dout_ready;
      dout_prev  = bus.dout;
      last_prev  = bus.dout_last;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Called at posedge+#1: waits for idle, then presents one load cycle.
  task automatic issue(input logic [N-1:0] v);
    int guard = 0;
    while (bus.busy && guard < 100) begin step(); guard++; end
    if (bus.busy) chk("issue_timeout", 1, 0);
    bus.din  = v;
    bus.load = 1'b1;
    push_model(v);
    step();
    bus.load = 1'b0;
    bus.din  = N'($urandom);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!bus.done && n < 50) begin step(); n++; end
    if (!bus.done) chk("done_timeout", 1, 0);
  endtask

  initial begin
    int n;
    rst_n          = 1'b0;
    bus.din        = '0;
    bus.load       = 1'b0;
    bus.dout_ready = 1'b0;
    #2;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_valid", int'(bus.dout_valid), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_zero", int'(bus.zero), 0);
    chk("rst_dout", int'(bus.dout), 0);
    chk("rst_last", int'(bus.dout_last), 0);
    #20 rst_n = 1'b1;
    step();

    // 1011 at full rate: k=3 completes 4 cycles after load.
    bus.dout_ready = 1'b1;
    issue(4'b1011);
    chk("lat_first_valid", int'(bus.dout_valid), 1);
    chk("first_idx_1011", int'(bus.dout), first_idx(4'b1011));
    wait_done(n);
    chk("lat_done_1011", n + 1, 4);
    chk("idle_after_done", int'(bus.busy), 0);

    // Empty vector: single done/zero pulse, never busy.
    step();
    issue(4'b0000);
    chk("empty_done", int'(bus.done), 1);
    chk("empty_zero", int'(bus.zero), 1);
    chk("empty_busy", int'(bus.busy), 0);
    chk("empty_valid", int'(bus.dout_valid), 0);
    step();
    chk("empty_done_pulse", int'(bus.done), 0);
    chk("empty_zero_pulse", int'(bus.zero), 0);

    // Backpressure: first index held three cycles.
    bus.dout_ready = 1'b0;
    issue(4'b0110);
    for (int c = 0; c < 3; c++) begin
      chk("hold_dout", int'(bus.dout), first_idx(4'b0110));
      chk("hold_valid", int'(bus.dout_valid), 1);
      if (c < 2) step();
    end
    bus.dout_ready = 1'b1;
    wait_done(n);
    chk("lat_done_0110", n, 2);

    // Load during SCAN ignored, load on the done cycle accepted.
    step();
    issue(4'b1100);
    bus.din  = 4'b0001;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    step();
    chk("done_cycle", int'(bus.done), 1);
    issue(4'b0001);
    chk("reload_valid", int'(bus.dout_valid), 1);
    chk("reload_dout", int'(bus.dout), 0);
    chk("reload_last", int'(bus.dout_last), 1);
    wait_done(n);

    // 1111 at full rate: done 5 cycles after load.
    step();
    issue(4'b1111);
    wait_done(n);
    chk("lat_done_1111", n + 1, 5);

    // Reset mid-SCAN after two handshakes discards everything.
    step();
    issue(4'b1111);
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_valid", int'(bus.dout_valid), 0);
    chk("mid_rst_dout", int'(bus.dout), 0);
    chk("mid_rst_last", int'(bus.dout_last), 0);
    chk("mid_rst_done", int'(bus.done), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (6) step();
    chk("post_rst_idle", int'(bus.busy), 0);

    // Randomized loads, ignored loads and backpressure.
    for (int c = 0; c < 400; c++) begin
      logic [N-1:0] v;
      v = N'($urandom);
      bus.dout_ready = ($urandom_range(0, 3) != 0);
      if (!bus.busy && ($urandom_range(0, 2) == 0)) begin
        bus.din  = v;
        bus.load = 1'b1;
        push_model(v);
      end else if (bus.busy && ($urandom_range(0, 3) == 0)) begin
        bus.din  = v;
        bus.load = 1'b1;
      end else begin
        bus.load = 1'b0;
      end
      step();
    end
    bus.load       = 1'b0;
    bus.dout_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin step(); n++; end
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/priority_encoder_serial.md
# priority_encoder_serial

- Sequential priority encoder: captures an N-bit request vector and emits, one per handshake, the binary index of every set bit, in priority order.
- Complements the team's one-hot decoders by converting a multi-hot vector back to a stream of indices.
- Sits between status/interrupt vectors and downstream logic that consumes a single index per transfer.

## Interface
Parameters:
- N, 4: width of request vector; power of two, ≥ 2.
- W, $clog2(N): index width (derived; do not override).

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- din  input  N  request vector, sampled on accepted load.
- load  input  1  capture din; accepted only when busy=0.
- busy  output  1  1 while a vector is being serialized.
- dout  output  W  index of current set bit.
- dout_valid  output  1  dout is valid.
- dout_ready  input  1  downstream accepts dout.
- dout_last  output  1  current dout is the final set bit of the vector.
- done  output  1  one-cycle pulse when a vector has been fully consumed (or was empty).
- zero  output  1  one-cycle pulse, coincident with done, when the loaded vector was all zeros.

## Operation
- State machine with states IDLE and SCAN. Internal register pend[N-1:0] holds the not-yet-emitted bits.
- IDLE: busy=0, dout_valid=0.
  - load=1 with din≠0: next cycle → SCAN.
    - dout = index of the highest-priority set bit, dout_valid=1.
    - pend = din with that bit cleared.
    - dout_last = (pend==0).
  - load=1 with din==0: stay in IDLE; done=1 and zero=1 next cycle; no dout_valid.
- SCAN: busy=1, dout_valid=1.
  - dout_valid && !dout_ready: dout, dout_last and pend hold.
  - Handshake with pend≠0: load the next index from pend, clear that bit in pend, recompute dout_last. dout_valid stays 1.
  - Handshake with dout_last=1: next cycle dout_valid=0, busy=0, done=1 → IDLE.
- load while busy=1 is ignored and din is not sampled.
- load is accepted in the cycle done is high, because the state is already IDLE.
- Default priority: lowest index first (bit 0 highest).
- Each set bit is emitted exactly once; a vector with k set bits produces exactly k handshakes.

## Timing
- Reset (rst_n=0, asynchronous):
  - busy, dout, dout_valid, dout_last, done, zero = 0; pend=0; state=IDLE.
  - Reset asserted mid-SCAN discards all pending bits; no done pulse.
- Latency:
  - Accepted load → first dout_valid: 1 cycle.
  - Last handshake → done pulse: 1 cycle.
  - Empty load → done/zero pulse: 1 cycle.
- Throughput: one index per cycle while dout_ready=1.
- A vector with k set bits and dout_ready held high completes in k+1 cycles from load to done.
- All outputs are registered; no combinational path from din, load or dout_ready to any output.
- dout, dout_last and dout_valid are stable while dout_valid=1 and dout_ready=0.
- done and zero are single-cycle pulses that never coincide with dout_valid=1.

## Configuration
- PENC_MSB_FIRST_EN:
  - Defined: priority is highest index first (bit N-1 emitted first).
  - Undefined: lowest index first (bit 0 emitted first).
  - All handshake and timing rules are identical in both builds.

## Test plan
- N=4, load din=4'b1011, dout_ready=1 → dout 0, 1, 3 on consecutive cycles; dout_last only with 3; done one cycle later; with PENC_MSB_FIRST_EN, order is 3, 1, 0.
- load din=4'b0000 → no dout_valid; done=1 and zero=1 for exactly one cycle, 1 cycle after load; busy stays 0.
- din=4'b0110, dout_ready held 0 for 3 cycles then 1 → dout=1 held stable 3 cycles; then 1, 2 emitted; done one cycle after index 2 is accepted.
- load din=4'b0001 during SCAN of 4'b1100 → ignored; only 2, 3 emitted. Then load din=4'b0001 on the done cycle → accepted, dout=0 with dout_last=1 next cycle.
- Assert rst_n=0 mid-SCAN of 4'b1111 after two handshakes → all outputs 0 immediately. After release, no residual indices are emitted and no done pulse appears.
- din=4'b1111, dout_ready=1 → 4 consecutive valid cycles (0, 1, 2, 3); done at cycle 5 after load.
